// File: rtl/vanilla_pkg.sv
// Shared types and constants for the Wishbone MMIO responder.
package vanilla_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STROBE,
    WAIT,
    ACK,
    HOLD
  } wb_resp_state_t;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/io_map.svh
// MMIO bus widths shared by the bridge-side responder and the slot cores.
`ifndef IO_MAP_SVH
`define IO_MAP_SVH
`define MMIO_ADDR_WIDTH 16
`define DATA_WIDTH 32
`endif

// File: rtl/mmio_slot_decoder.sv
// Slot index to one-hot select; out-of-range indices select nothing.
module mmio_slot_decoder #(
  parameter int NUM_SLOTS = 64,
  parameter int SLOT_BITS = 6
) (
  input  logic [SLOT_BITS-1:0] slot,
  output logic [NUM_SLOTS-1:0] sel
);

  always_comb begin
    sel = '0;
    if ({1'b0, slot} < (SLOT_BITS+1)'(NUM_SLOTS))
      sel[slot] = 1'b1;
  end

endmodule

// File: rtl/wb_mmio_responder.sv
// Wishbone classic responder fanning bridge transfers out to MMIO slots.
`include "io_map.svh"

module wb_mmio_responder
  import vanilla_pkg::*;
#(
  parameter int NUM_SLOTS = 64,
  parameter int SLOT_BITS = 6,
  parameter int REG_BITS  = 5,
  parameter int TIMEOUT   = 16
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  CYC_I,
  input  logic                                  STB_I,
  input  logic                                  WE_I,
  input  logic [`MMIO_ADDR_WIDTH-1:0]           ADDR_I,
  input  logic [`DATA_WIDTH-1:0]                DAT_I,
  output logic [`DATA_WIDTH-1:0]                DAT_O,
  output logic                                  ACK_O,
  output logic                                  ERR_O,
  output logic [NUM_SLOTS-1:0]                  slot_cs,
  output logic                                  slot_rd,
  output logic                                  slot_wr,
  output logic [REG_BITS-1:0]                   slot_reg,
  output logic [`DATA_WIDTH-1:0]                slot_wdata,
  input  logic [NUM_SLOTS-1:0][`DATA_WIDTH-1:0] slot_rdata,
  input  logic [NUM_SLOTS-1:0]                  slot_ready
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  wb_resp_state_t         state;
  logic [SLOT_BITS-1:0]   slot_q;
  logic                   we_q;
  logic [CW-1:0]          cnt;
  logic [NUM_SLOTS-1:0]   sel;
  logic                   req;
  logic                   rdy;
  logic                   in_range;
  logic [`DATA_WIDTH-1:0] rdata;
  logic                   unused_addr;

  assign req = CYC_I & STB_I;
  assign unused_addr =
    ^ADDR_I[`MMIO_ADDR_WIDTH-1:REG_BITS+SLOT_BITS];

  mmio_slot_decoder #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_BITS (SLOT_BITS)
  ) u_dec (
    .slot (ADDR_I[REG_BITS+SLOT_BITS-1:REG_BITS]),
    .sel  (sel)
  );

  // Only the latched slot may answer; others' ready is ignored.
  assign in_range = {1'b0, slot_q} < (SLOT_BITS+1)'(NUM_SLOTS);

  always_comb begin
    rdy   = 1'b0;
    rdata = '0;
    if (in_range) begin
      rdy   = slot_ready[slot_q];
      rdata = slot_rdata[slot_q];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      slot_q     <= '0;
      we_q       <= 1'b0;
      cnt        <= '0;
      DAT_O      <= '0;
      ACK_O      <= 1'b0;
      ERR_O      <= 1'b0;
      slot_cs    <= '0;
      slot_rd    <= 1'b0;
      slot_wr    <= 1'b0;
      slot_reg   <= '0;
      slot_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            slot_q     <= ADDR_I[REG_BITS+SLOT_BITS-1:REG_BITS];
            slot_reg   <= ADDR_I[REG_BITS-1:0];
            we_q       <= WE_I;
            slot_wdata <= DAT_I;
            slot_cs    <= sel;
            slot_rd    <= ~WE_I;
            slot_wr    <= WE_I;
            state      <= STROBE;
          end
        end
        STROBE: begin
          slot_rd <= 1'b0;
          slot_wr <= 1'b0;
          cnt     <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (rdy) begin
            if (!we_q) DAT_O <= rdata;
            slot_cs <= '0;
            ACK_O   <= 1'b1;
            state   <= ACK;
          end else if (cnt == CNT_LAST) begin
            if (!we_q) DAT_O <= ERR_DATA;
            slot_cs <= '0;
            ERR_O   <= 1'b1;
            ACK_O   <= 1'b1;
            state   <= ACK;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        ACK: begin
          ACK_O <= 1'b0;
          ERR_O <= 1'b0;
          state <= HOLD;
        end
        HOLD: begin
          // A held strobe must not re-issue a side-effecting read.
          if (!STB_I) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
